// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: memory op encoding, FSM states
// and op classification helpers.
package mem_access_stage_pkg;

    typedef enum logic [2:0] {
        MEM_NONE = 3'd0,
        MEM_LW   = 3'd1,
        MEM_LBU  = 3'd2,
        MEM_SW   = 3'd3,
        MEM_SB   = 3'd4
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        RETIRE
    } ms_state_e;

    function automatic logic is_store(input mem_op_e op);
        return (op == MEM_SW) || (op == MEM_SB);
    endfunction

    function automatic logic is_load(input mem_op_e op);
        return (op == MEM_LW) || (op == MEM_LBU);
    endfunction

endpackage

// File: rtl/mem_access_stage_byte_lane.sv
// Combinational byte-lane steering: store byte enables / write data and
// LBU byte extraction from a returned load word.
module mem_byte_lane
    import mem_access_stage_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rsp_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    always_comb begin
        be    = '0;
        wdata = store_data;
        case (op)
            MEM_SW: be = 4'b1111;
            MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = rsp_data;
        if (op == MEM_LBU) begin
            load_data = {24'h0, rsp_data[{addr_lo, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: registers the ALU result, issues at most one data
// memory access, retires to writeback and pulses the branch/JALR redirect.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned RF_ADDR_W   = 5,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [31:0]          alu_result_i,
    input  logic [31:0]          store_data_i,
    input  logic                 is_branch_i,
    input  logic                 jump_now_i,
    input  logic [31:0]          jump_target_i,
    input  logic [2:0]           mem_op_i,
    input  logic                 wb_en_i,
    input  logic [RF_ADDR_W-1:0] wb_addr_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic [3:0]           mem_be_o,
    input  logic                 mem_rsp_valid_i,
    input  logic [31:0]          mem_rsp_data_i,
    output logic                 wb_valid_o,
    output logic                 wb_en_o,
    output logic [RF_ADDR_W-1:0] wb_addr_o,
    output logic [31:0]          wb_data_o,
    output logic                 redirect_o,
    output logic [31:0]          redirect_pc_o,
    output logic                 mem_err_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    ms_state_e            state_q, state_d;
    mem_op_e              op_q, op_in;
    logic [31:0]          addr_q, sdata_q, wb_data_q, redirect_pc_q;
    logic [RF_ADDR_W-1:0] wb_addr_q;
    logic                 wb_en_q, redirect_q, err_q;
    logic [7:0]           tmo_q;

    logic        accept, misaligned_lw, tmo_expire;
    logic        capture_rsp, set_err, abort;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_load;

    assign op_in         = mem_op_e'(mem_op_i);
    assign accept        = ex_valid_i && (state_q == IDLE);
    assign misaligned_lw = (op_in == MEM_LW) && (alu_result_i[1:0] != 2'b00);
    assign tmo_expire    = (tmo_q == TMO_LAST);

    mem_byte_lane u_lane (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (sdata_q),
        .rsp_data   (mem_rsp_data_i),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    always_comb begin
        state_d     = state_q;
        capture_rsp = 1'b0;
        set_err     = 1'b0;
        abort       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned_lw) begin
                        set_err = 1'b1;
                        state_d = RETIRE;
                    end else if (is_load(op_in) || is_store(op_in)) begin
                        state_d = REQ;
                    end else begin
                        state_d = RETIRE;
                    end
                end
            end
            REQ: begin
                // A completing handshake wins over an expiring timeout
                if (mem_req_ready_i && is_store(op_q)) begin
                    state_d = RETIRE;
                end else if (mem_req_ready_i && mem_rsp_valid_i) begin
                    capture_rsp = 1'b1;
                    state_d     = RETIRE;
                end else if (tmo_expire) begin
                    abort   = 1'b1;
                    set_err = 1'b1;
                    state_d = RETIRE;
                end else if (mem_req_ready_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    capture_rsp = 1'b1;
                    state_d     = RETIRE;
                end else if (tmo_expire) begin
                    abort   = 1'b1;
                    set_err = 1'b1;
                    state_d = RETIRE;
                end
            end
            RETIRE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= MEM_NONE;
            addr_q        <= '0;
            sdata_q       <= '0;
            wb_data_q     <= '0;
            wb_addr_q     <= '0;
            wb_en_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            err_q         <= 1'b0;
            tmo_q         <= '0;
        end else begin
            state_q    <= state_d;
            redirect_q <= accept && is_branch_i && jump_now_i;
            if (set_err) err_q <= 1'b1;
            if (state_q == REQ || state_q == WAIT_RSP) tmo_q <= tmo_q + 8'd1;
            else                                        tmo_q <= '0;
            if (accept) begin
                op_q          <= op_in;
                addr_q        <= alu_result_i;
                sdata_q       <= store_data_i;
                wb_data_q     <= alu_result_i;
                wb_addr_q     <= wb_addr_i;
                wb_en_q       <= wb_en_i && !is_store(op_in) && !misaligned_lw;
                redirect_pc_q <= jump_target_i;
            end
            if (capture_rsp) wb_data_q <= lane_load;
            if (abort)       wb_en_q   <= 1'b0;
        end
    end

    assign ex_ready_o      = (state_q == IDLE);
    assign mem_req_valid_o = (state_q == REQ);
    assign mem_we_o        = mem_req_valid_o && is_store(op_q);
    assign mem_addr_o      = mem_req_valid_o ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wdata_o     = mem_req_valid_o ? lane_wdata : '0;
    assign mem_be_o        = mem_req_valid_o ? lane_be : '0;
    assign wb_valid_o      = (state_q == RETIRE);
    assign wb_en_o         = wb_en_q;
    assign wb_addr_o       = wb_addr_q;
    assign wb_data_o       = wb_data_q;
    assign redirect_o      = redirect_q;
    assign redirect_pc_o   = redirect_pc_q;
    assign mem_err_o       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int unsigned TMO = 8;

    logic        clk, reset;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_result, store_data, jump_target;
    logic        is_branch, jump_now, wb_en_in;
    logic [2:0]  mem_op;
    logic [4:0]  wb_addr_in;
    logic        req_valid, req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        wb_valid, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.RF_ADDR_W(5), .TIMEOUT_CYC(TMO)) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_valid_i      (ex_valid),
        .ex_ready_o      (ex_ready),
        .alu_result_i    (alu_result),
        .store_data_i    (store_data),
        .is_branch_i     (is_branch),
        .jump_now_i      (jump_now),
        .jump_target_i   (jump_target),
        .mem_op_i        (mem_op),
        .wb_en_i         (wb_en_in),
        .wb_addr_i       (wb_addr_in),
        .mem_req_valid_o (req_valid),
        .mem_req_ready_i (req_ready),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_be_o        (mem_be),
        .mem_rsp_valid_i (rsp_valid),
        .mem_rsp_data_i  (rsp_data),
        .wb_valid_o      (wb_valid),
        .wb_en_o         (wb_en),
        .wb_addr_o       (wb_addr),
        .wb_data_o       (wb_data),
        .redirect_o      (redirect),
        .redirect_pc_o   (redirect_pc),
        .mem_err_o       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd,
                             input logic br, input logic jn, input logic [31:0] tgt,
                             input logic wen, input logic [4:0] wad);
        ex_valid    = 1'b1;
        mem_op      = op;
        alu_result  = addr;
        store_data  = sd;
        is_branch   = br;
        jump_now    = jn;
        jump_target = tgt;
        wb_en_in    = wen;
        wb_addr_in  = wad;
    endtask

    // Presents one instruction at a negedge; returns at the next negedge with ex_valid dropped.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic br, input logic jn, input logic [31:0] tgt,
                         input logic wen, input logic [4:0] wad);
        set_instr(op, addr, sd, br, jn, tgt, wen, wad);
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; mem_op = '0; alu_result = '0; store_data = '0;
        is_branch = 1'b0; jump_now = 1'b0; jump_target = '0; wb_en_in = 1'b0; wb_addr_in = '0;
        req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ex_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_err", mem_err, 0);
        check("rst_redirect", redirect, 0);
        check("rst_wb_data", wb_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // Pass-through, 1-cycle latency
        issue(MEM_NONE, 32'h1234_5678, 0, 0, 0, 0, 1, 5);
        check("none_wb_valid", wb_valid, 1);
        check("none_wb_data", wb_data, 32'h1234_5678);
        check("none_wb_addr", wb_addr, 5);
        check("none_wb_en", wb_en, 1);
        check("none_busy", ex_ready, 0);
        check("none_no_req", req_valid, 0);
        @(negedge clk);
        check("none_ready_back", ex_ready, 1);
        check("none_wb_pulse", wb_valid, 0);

        // LBU at 0x103, response after two wait cycles
        issue(MEM_LBU, 32'h0000_0103, 0, 0, 0, 0, 1, 7);
        check("lbu_req_valid", req_valid, 1);
        check("lbu_addr", mem_addr, 32'h100);
        check("lbu_we", mem_we, 0);
        check("lbu_busy_req", ex_ready, 0);
        @(negedge clk);
        check("lbu_req_dropped", req_valid, 0);
        check("lbu_busy_w1", ex_ready, 0);
        check("lbu_no_wb_w1", wb_valid, 0);
        @(negedge clk);
        check("lbu_busy_w2", ex_ready, 0);
        rsp_valid = 1'b1; rsp_data = 32'hAABB_CCDD;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("lbu_wb_valid", wb_valid, 1);
        check("lbu_wb_data", wb_data, 32'h0000_00AA);
        check("lbu_wb_en", wb_en, 1);
        check("lbu_wb_addr", wb_addr, 7);
        check("lbu_busy_ret", ex_ready, 0);
        @(negedge clk);
        check("lbu_ready_back", ex_ready, 1);

        // SB at 0x202 with ready held off 3 cycles; ALU keeps ex_valid up while busy
        req_ready = 1'b0;
        set_instr(MEM_SB, 32'h0000_0202, 32'h0000_00EE, 0, 0, 0, 1, 9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) req_ready = 1'b1;
            check("sb_req_valid", req_valid, 1);
            check("sb_be", mem_be, 4'b0100);
            check("sb_wdata", mem_wdata, 32'hEEEE_EEEE);
            check("sb_addr", mem_addr, 32'h200);
            check("sb_we", mem_we, 1);
            check("sb_busy", ex_ready, 0);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        check("sb_wb_valid", wb_valid, 1);
        check("sb_wb_en", wb_en, 0);
        check("sb_req_done", req_valid, 0);
        @(negedge clk);
        check("sb_ready_back", ex_ready, 1);
        check("sb_no_reaccept", wb_valid, 0);

        // Misaligned LW
        issue(MEM_LW, 32'h0000_0006, 0, 0, 0, 0, 1, 3);
        check("mis_no_req", req_valid, 0);
        check("mis_err", mem_err, 1);
        check("mis_wb_valid", wb_valid, 1);
        check("mis_wb_en", wb_en, 0);
        @(negedge clk);
        check("mis_err_sticky", mem_err, 1);

        // Redirects: taken, not taken, non-branch with jump_now set
        issue(MEM_NONE, 32'h0000_1004, 0, 1, 1, 32'h40, 1, 1);
        check("br_redirect", redirect, 1);
        check("br_pc", redirect_pc, 32'h40);
        check("br_link", wb_data, 32'h0000_1004);
        check("br_link_valid", wb_valid, 1);
        @(negedge clk);
        check("br_pulse_end", redirect, 0);
        issue(MEM_NONE, 32'h0000_2008, 0, 1, 0, 32'h80, 0, 0);
        check("nt_redirect", redirect, 0);
        @(negedge clk);
        issue(MEM_NONE, 32'h0000_0000, 0, 0, 1, 32'h90, 0, 0);
        check("nb_redirect", redirect, 0);
        @(negedge clk);

        // Timeout: request never accepted
        req_ready = 1'b0;
        issue(MEM_LW, 32'h0000_0030, 0, 0, 0, 0, 1, 4);
        check("tmo_req_first", req_valid, 1);
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            check("tmo_req_held", req_valid, 1);
        end
        @(negedge clk);
        check("tmo_req_drop", req_valid, 0);
        check("tmo_wb_valid", wb_valid, 1);
        check("tmo_wb_en", wb_en, 0);
        check("tmo_err", mem_err, 1);
        req_ready = 1'b1;
        @(negedge clk);

        // Reset while waiting for a load response, then a late response
        issue(MEM_LW, 32'h0000_0010, 0, 0, 0, 0, 1, 2);
        @(negedge clk);
        check("rmid_waiting", ex_ready, 0);
        reset = 1'b1;
        #1;
        check("rmid_ready", ex_ready, 1);
        check("rmid_err_clr", mem_err, 0);
        check("rmid_wb_valid", wb_valid, 0);
        check("rmid_wb_data", wb_data, 0);
        @(negedge clk);
        reset = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("late_rsp_ignored", wb_valid, 0);
            check("late_ready", ex_ready, 1);
        end

        // Same-cycle ready+response in REQ (rsp_valid already high in IDLE is ignored)
        rsp_data = 32'h1122_3344;
        issue(MEM_LW, 32'h0000_0020, 0, 0, 0, 0, 1, 6);
        check("fast_req", req_valid, 1);
        @(negedge clk);
        rsp_valid = 1'b0;
        check("fast_wb_valid", wb_valid, 1);
        check("fast_wb_data", wb_data, 32'h1122_3344);
        check("fast_wb_addr", wb_addr, 6);
        @(negedge clk);

        // Normal LW, 3-cycle latency
        issue(MEM_LW, 32'h0000_0044, 0, 0, 0, 0, 1, 8);
        check("lw_req", req_valid, 1);
        check("lw_addr", mem_addr, 32'h44);
        @(negedge clk);
        check("lw_wait_no_wb", wb_valid, 0);
        rsp_valid = 1'b1; rsp_data = 32'hCAFE_F00D;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("lw_wb_valid", wb_valid, 1);
        check("lw_wb_data", wb_data, 32'hCAFE_F00D);
        check("lw_wb_en", wb_en, 1);
        check("lw_err_clear", mem_err, 0);
        @(negedge clk);

        // LBU byte 0, SW byte enables
        issue(MEM_SW, 32'h0000_0050, 32'h0102_0304, 0, 0, 0, 1, 10);
        check("sw_be", mem_be, 4'b1111);
        check("sw_wdata", mem_wdata, 32'h0102_0304);
        @(negedge clk);
        check("sw_wb_en", wb_en, 0);
        @(negedge clk);
        issue(MEM_LBU, 32'h0000_0060, 0, 0, 0, 0, 1, 11);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 32'h1234_5699;
        @(negedge clk);
        rsp_valid = 1'b0;
        check("lbu0_wb_data", wb_data, 32'h0000_0099);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
